// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Buffers CPU writes to VRAM in a small FIFO and drains them to the GPU VRAM
//   port one entry per clock, but only while the video timing says VRAM is
//   writable. Writes arriving while the FIFO is full are dropped and flagged.
//
// Parameters
//   DEPTH  FIFO entries (power of two, 4..64)
//   CW     occupancy-count width, derived as log2(DEPTH)+1 (do not override)
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   wr_en         CPU write request
//   wr_address    CPU target VRAM address (`VRAM_ADDR_WIDTH bits)
//   wr_data       CPU write data
//   writable      1 = VRAM may be updated this cycle
//   ovf_clear     clears overflow (and drop_count)
//   vram_we       one-cycle write strobe to VRAM
//   vram_address  registered write address
//   vram_data     registered write data
//   full, empty   registered FIFO status
//   count         current occupancy
//   overflow      sticky "a write was dropped"
//   drop_count    saturating count of dropped writes
//
// Build option
//   VRAM_WSCHED_DROP_COUNT_EN  when defined, drop_count is a real saturating
//                              counter; otherwise it is tied to zero.

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_write_scheduler #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [`VRAM_ADDR_WIDTH-1:0] wr_address,
  input  logic [7:0]                  wr_data,
  input  logic                        writable,
  input  logic                        ovf_clear,
  output logic                        vram_we,
  output logic [`VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]                  vram_data,
  output logic                        full,
  output logic                        empty,
  output logic [CW-1:0]               count,
  output logic                        overflow,
  output logic [7:0]                  drop_count
);

  localparam int AW = `VRAM_ADDR_WIDTH;
  localparam int IW = CW - 1;  // pointer index width; bit IW is the wrap bit
  localparam int EW = AW + 8;  // stored entry: {address, data}

  logic [EW-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          full_reg, full_next;
  logic          empty_reg, empty_next;
  logic [CW-1:0] count_reg, count_next;
  logic          vram_we_reg;
  logic [AW-1:0] vram_address_reg;
  logic [7:0]    vram_data_reg;
  logic          overflow_reg, overflow_next;

  logic push;
  logic pop;
  logic drop;

  // Acceptance uses the registered (pre-edge) flags only, so a pop on the
  // same edge never frees a slot for a push that arrived while full.
  assign push = wr_en & ~full_reg;
  assign pop  = writable & ~empty_reg;
  assign drop = wr_en & full_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg + CW'(push);
    rd_ptr_next = rd_ptr_reg + CW'(pop);
    // Same index with differing wrap bits means the writer lapped the reader.
    full_next   = (wr_ptr_next[IW] != rd_ptr_next[IW]) &&
                  (wr_ptr_next[IW-1:0] == rd_ptr_next[IW-1:0]);
    empty_next  = (wr_ptr_next == rd_ptr_next);
    count_next  = wr_ptr_next - rd_ptr_next;
  end

  // Set beats clear so a drop coinciding with ovf_clear is never lost.
  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ovf_clear) begin
      overflow_next = 1'b0;
    end
  end

  // Storage carries no reset so it can map onto block RAM; stale contents are
  // unreachable once the pointers are zeroed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[IW-1:0]] <= {wr_address, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      count_reg        <= '0;
      vram_we_reg      <= 1'b0;
      vram_address_reg <= '0;
      vram_data_reg    <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      full_reg     <= full_next;
      empty_reg    <= empty_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      vram_we_reg  <= pop;
      // Address/data hold their last popped values when nothing is drained.
      if (pop) begin
        {vram_address_reg, vram_data_reg} <= mem[rd_ptr_reg[IW-1:0]];
      end
    end
  end

`ifdef VRAM_WSCHED_DROP_COUNT_EN
  logic [7:0] drop_count_reg, drop_count_next;

  // A clear that coincides with a drop restarts the count at one, matching
  // the overflow flag staying set.
  always_comb begin
    drop_count_next = drop_count_reg;
    if (ovf_clear) begin
      drop_count_next = 8'd0;
    end
    if (drop && (drop_count_next != 8'hFF)) begin
      drop_count_next = drop_count_next + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_reg <= 8'd0;
    end else begin
      drop_count_reg <= drop_count_next;
    end
  end

  assign drop_count = drop_count_reg;
`else
  assign drop_count = 8'd0;
`endif

  assign vram_we      = vram_we_reg;
  assign vram_address = vram_address_reg;
  assign vram_data    = vram_data_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed testbench for vram_write_scheduler (DEPTH=16).
// Inputs change 1 ns after each rising edge; outputs are checked at the same
// point, so every check observes the state produced by the preceding edge.

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module tb_vram_write_scheduler;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int AW    = `VRAM_ADDR_WIDTH;

`ifdef VRAM_WSCHED_DROP_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_address;
  logic [7:0]    wr_data;
  logic          writable;
  logic          ovf_clear;
  logic          vram_we;
  logic [AW-1:0] vram_address;
  logic [7:0]    vram_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_count;

  int vectors     = 0;
  int miscompares = 0;

  vram_write_scheduler #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_address   (wr_address),
    .wr_data      (wr_data),
    .writable     (writable),
    .ovf_clear    (ovf_clear),
    .vram_we      (vram_we),
    .vram_address (vram_address),
    .vram_data    (vram_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [AW-1:0] a, input logic [7:0] d);
    chk({tag, "_we"},   32'(vram_we), 32'd1);
    chk({tag, "_addr"}, 32'(vram_address), 32'(a));
    chk({tag, "_data"}, 32'(vram_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_address = '0; wr_data = '0;
    writable = 1'b0; ovf_clear = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_we",    32'(vram_we), 32'd0);
    chk("rst_addr",  32'(vram_address), 32'd0);
    chk("rst_data",  32'(vram_data), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_drop",  32'(drop_count), 32'd0);
    rst = 1'b0;
    writable = 1'b1;
    tick();
    chk("post_rst_we", 32'(vram_we), 32'd0);

    // Three writes outside the window, then drain in order
    writable = 1'b0;
    wr_en = 1'b1; wr_address = 12'h010; wr_data = 8'hAA; tick();
    wr_address = 12'h011; wr_data = 8'hBB; tick();
    wr_address = 12'h012; wr_data = 8'hCC; tick();
    chk("w3_we_idle", 32'(vram_we), 32'd0);
    chk("w3_count", 32'(count), 32'd3);
    wr_en = 1'b0; writable = 1'b1;
    tick(); chk_wr("w3_0", 12'h010, 8'hAA);
    tick(); chk_wr("w3_1", 12'h011, 8'hBB);
    tick(); chk_wr("w3_2", 12'h012, 8'hCC);
    chk("w3_count_end", 32'(count), 32'd0);
    chk("w3_empty_end", 32'(empty), 32'd1);
    tick();
    chk("w3_we_off", 32'(vram_we), 32'd0);
    chk("w3_addr_hold", 32'(vram_address), 32'h012);
    chk("w3_data_hold", 32'(vram_data), 32'hCC);

    // Single write in an open window: strobe only after the second edge
    wr_en = 1'b1; wr_address = 12'h345; wr_data = 8'h5A; tick();
    wr_en = 1'b0;
    chk("lat_edge_k", 32'(vram_we), 32'd0);
    chk("lat_count", 32'(count), 32'd1);
    tick(); chk_wr("lat_k1", 12'h345, 8'h5A);
    tick(); chk("lat_k2_we", 32'(vram_we), 32'd0);

    // 18 writes into a closed window: two dropped
    writable = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_address = AW'(12'h100 + i); wr_data = 8'(i); tick();
      if (i == 15) begin
        chk("fill_full16", 32'(full), 32'd1);
        chk("fill_count16", 32'(count), 32'd16);
        chk("fill_ovf16", 32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    chk("fill_full18", 32'(full), 32'd1);
    chk("fill_count18", 32'(count), 32'd16);
    chk("fill_ovf18", 32'(overflow), 32'd1);
    chk("fill_drop18", 32'(drop_count), DC_EN ? 32'd2 : 32'd0);

    // Clear coinciding with another overflowing write: overflow stays set
    ovf_clear = 1'b1; wr_en = 1'b1; wr_address = 12'h1EE; tick();
    chk("clr_set_ovf", 32'(overflow), 32'd1);
    chk("clr_set_drop", 32'(drop_count), DC_EN ? 32'd1 : 32'd0);
    wr_en = 1'b0; tick();
    ovf_clear = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);

    // Full FIFO, pop and push on the same edge: push rejected
    writable = 1'b1; wr_en = 1'b1; wr_address = 12'h1FF; wr_data = 8'hFF; tick();
    wr_en = 1'b0;
    chk("fp_count", 32'(count), 32'd15);
    chk("fp_ovf", 32'(overflow), 32'd1);
    chk("fp_full", 32'(full), 32'd0);
    chk_wr("fp_pop0", 12'h100, 8'h00);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk_wr($sformatf("drain_%0d", i), AW'(12'h100 + i), 8'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    tick();
    chk("drain_we_off", 32'(vram_we), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Window closes mid-drain, then reset discards the rest
    writable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_address = AW'(12'h200 + i); wr_data = 8'(8'h80 + i); tick();
    end
    wr_en = 1'b0; writable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr($sformatf("part_%0d", i), AW'(12'h200 + i), 8'(8'h80 + i));
    end
    writable = 1'b0; tick();
    chk("part_we_stop", 32'(vram_we), 32'd0);
    chk("part_count", 32'(count), 32'd5);
    writable = 1'b1; rst = 1'b1; tick();
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_we", 32'(vram_we), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_addr", 32'(vram_address), 32'd0);
    rst = 1'b0; tick();
    chk("mrst_we_after1", 32'(vram_we), 32'd0);
    tick();
    chk("mrst_we_after2", 32'(vram_we), 32'd0);
    chk("mrst_count_after", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
